shift_add_sequencer: RTL
========================

SHIFT_ADD_SEQUENCER -- requirements
Module: shift_add_sequencer

Interface
REQ-001: Parameter parallelism, default 8: width of operand A, equal to the barrel shifter's in_data width.
REQ-002: Parameter depth, default 3: shifter control width; operand B width NB = 2**depth (8).
REQ-003: Derived widths: SW = parallelism+NB-1 (15), the shifter output width; RW = parallelism+NB (16), the result width.
REQ-004: The block has one clock, clk, and the reset rst_n is asynchronous and active-low.
REQ-005: clk  input  1  rising-edge clock for all state.
REQ-006: rst_n  input  1  asynchronous active-low reset.
REQ-007: start  input  1  request to load operands; sampled only in IDLE.
REQ-008: a_in  input  parallelism  multiplicand A.
REQ-009: b_in  input  NB  multiplier B.
REQ-010: busy  output  1  high in RUN and DONE.
REQ-011: shift_in  output  parallelism  registered A; drives the shifter in_data.
REQ-012: shift_ctrl  output  depth  bit index; drives the shifter control.
REQ-013: shift_data  input  SW  combinational shifter output, shift_in << shift_ctrl, zero-extended.
REQ-014: result  output  RW  accumulated product A*B.
REQ-015: result_valid  output  1  result available.
REQ-016: result_ready  input  1  consumer accepts result.

Function
REQ-017: The FSM has exactly three states: IDLE, RUN, DONE.
REQ-018: In IDLE with start=1 at an edge: a_reg<=a_in, b_reg<=b_in, acc<=0, shift_ctrl<=0, next state RUN.
REQ-019: In IDLE with start=0, all registers hold their values.
REQ-020: In RUN at each edge: acc<=acc+(b_reg[shift_ctrl] ? zero-extended shift_data : 0).
REQ-021: In RUN with shift_ctrl<NB-1: shift_ctrl increments by 1 and the state stays RUN.
REQ-022: In RUN with shift_ctrl=NB-1: after the final add, shift_ctrl wraps to 0 and the state becomes DONE.
REQ-023: RUN always lasts exactly NB cycles; there is no early termination on zero bits of B, including B=0.
REQ-024: Latency: start sampled at edge N gives result_valid=1 from edge N+NB+1 onward.
REQ-025: In DONE, result_valid=1 and result=acc, both stable until handshake.
REQ-026: The handshake completes when result_valid=1 and result_ready=1 at an edge; the state then returns to IDLE.
REQ-027: In DONE with result_ready=0, the state holds indefinitely.
REQ-028: start is ignored in RUN and DONE, including start coinciding with the DONE handshake.
REQ-029: A new operation therefore needs a start in IDLE; the minimum issue interval is NB+2 cycles.
REQ-030: acc is RW bits wide and never overflows: max (2**parallelism-1)*(2**NB-1) < 2**RW.
REQ-031: shift_in is driven from a_reg and is stable for the whole RUN.
REQ-032: The block makes no assumption on shift_data outside RUN.
REQ-033: result is driven from acc in all states.

Reset
REQ-034: rst_n=0 forces, immediately and independent of clk: state=IDLE, a_reg=0, b_reg=0, acc=0, shift_ctrl=0, busy=0, result_valid=0, result=0, shift_in=0.
REQ-035: Reset asserted mid-RUN or in DONE abandons the operation; no result_valid pulse follows.
REQ-036: After deassertion, the first accepted start behaves exactly as after power-up.

Verification
REQ-037: a_in=1, b_in=1, start at edge 0 -> shift_ctrl 0..7 on edges 1..8; result_valid=1 at edge 9 with result=1.
REQ-038: a_in=255, b_in=255 -> result=65025 (16'hFE01); a_in=255, b_in=8'h80 -> result=32640.
REQ-039: a_in=200, b_in=0 -> still 8 RUN cycles; result=0, result_valid=1 at edge 9.
REQ-040: a_in=3, b_in=5 with result_ready=0 for 20 cycles -> result=15 and result_valid=1 held throughout; start pulses during this window are ignored; handshake -> IDLE, busy=0.
REQ-041: rst_n=0 pulsed at RUN cycle 4 -> all outputs 0 asynchronously; then start with a_in=7, b_in=9 -> result=63.
REQ-042: Random A/B with random result_ready; a scoreboard compares result against A*B at every handshake, over 1000 operations.

Source files
------------

// File: rtl/shift_add_sequencer_if.sv
// Operand/result handshake plus the external barrel-shifter hookup for shift_add_sequencer.
// slave = the sequencer itself; master = whoever supplies operands, the shifter and the result sink.
interface shift_add_sequencer_if #(
    parameter int parallelism = 8,
    parameter int depth       = 3
);
    localparam int NB = 2 ** depth;
    localparam int SW = parallelism + NB - 1;
    localparam int RW = parallelism + NB;

    logic                   start;
    logic [parallelism-1:0] a_in;
    logic [NB-1:0]          b_in;
    logic                   busy;
    logic [parallelism-1:0] shift_in;
    logic [depth-1:0]       shift_ctrl;
    logic [SW-1:0]          shift_data;
    logic [RW-1:0]          result;
    logic                   result_valid;
    logic                   result_ready;

    modport slave (
        input  start, a_in, b_in, shift_data, result_ready,
        output busy, shift_in, shift_ctrl, result, result_valid
    );

    modport master (
        output start, a_in, b_in, shift_data, result_ready,
        input  busy, shift_in, shift_ctrl, result, result_valid
    );
endinterface

// File: rtl/shift_add_sequencer.sv
// Shift-and-add multiplier: one B bit per cycle through an external shifter, NB RUN cycles, result NB+1 edges after start.
// Result is held in DONE until result_ready; start is only honoured in IDLE.
module shift_add_sequencer #(
    parameter int parallelism = 8,
    parameter int depth       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_sequencer_if.slave bus
);
    localparam int NB = 2 ** depth;
    localparam int RW = parallelism + NB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [parallelism-1:0] a_q, a_d;
    logic [NB-1:0]          b_q, b_d;
    logic [RW-1:0]          acc_q, acc_d;
    logic [depth-1:0]       ctrl_q, ctrl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    acc_d   = '0;
                    ctrl_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Every bit position is visited, even when B is zero, so latency never depends on data.
                if (b_q[ctrl_q]) begin
                    acc_d = acc_q + RW'(bus.shift_data);
                end
                if (ctrl_q == depth'(NB - 1)) begin
                    ctrl_d  = '0;
                    state_d = DONE;
                end else begin
                    ctrl_d = ctrl_q + depth'(1);
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.result_valid = (state_q == DONE);
    assign bus.result       = acc_q;
    assign bus.shift_in     = a_q;
    assign bus.shift_ctrl   = ctrl_q;
endmodule
